// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter that merges several result producers onto one scoreboard writeback lane.
// Latency: an entry pushed in cycle N can appear on wb_* in cycle N+1; one writeback per cycle total.
// Backpressure: none on the writeback side; per-requester ready_o drops when its FIFO is full.

// Small synchronous FIFO used for each requester's result buffer.
// Latency: a push is visible at data_o on the next cycle; head is read combinationally.
// Backpressure: full_o blocks pushes, even in a cycle that also pops (no pass-through).
module wb_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             push_ok;
   logic             pop_ok;

   // Pointer advance with explicit wrap so any DEPTH (including 1) is handled.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);

   // A flush or reset cycle neither accepts nor releases entries.
   assign push_ok = push_i & ~full_o & ~flush_i & ~rst_i;
   assign pop_ok  = pop_i & ~empty_o & ~flush_i & ~rst_i;

   assign data_o = mem[rd_ptr_q];

   // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (pop_ok) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy guards every read.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= data_i;
      end
   end

endmodule

module wb_port_arbiter #(
   parameter int unsigned NR_REQ        = 3,
   parameter int unsigned DEPTH         = 2,
   parameter int unsigned XLEN          = 64,
   parameter int unsigned TRANS_ID_BITS = 3
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            flush_i,
   input  logic [NR_REQ-1:0]               req_valid_i,
   input  logic [NR_REQ*TRANS_ID_BITS-1:0] req_trans_id_i,
   input  logic [NR_REQ*XLEN-1:0]          req_data_i,
   input  logic [NR_REQ-1:0]               req_ex_valid_i,
   input  logic [NR_REQ*XLEN-1:0]          req_ex_cause_i,
   output logic [NR_REQ-1:0]               ready_o,
   output logic                            wb_valid_o,
   output logic [TRANS_ID_BITS-1:0]        wb_trans_id_o,
   output logic [XLEN-1:0]                 wb_data_o,
   output logic                            wb_ex_valid_o,
   output logic [XLEN-1:0]                 wb_ex_cause_o,
   output logic [NR_REQ-1:0]               grant_o,
   output logic                            overflow_o
);

   localparam int unsigned IDX_W = $clog2(NR_REQ);

   typedef struct packed {
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [XLEN-1:0]          data;
      logic                     ex_valid;
      logic [XLEN-1:0]          ex_cause;
   } wb_entry_t;

   localparam int unsigned ENTRY_W = $bits(wb_entry_t);

   wb_entry_t         push_ent [NR_REQ];
   wb_entry_t         head_ent [NR_REQ];
   wb_entry_t         wb_sel;
   logic [NR_REQ-1:0] fifo_full;
   logic [NR_REQ-1:0] fifo_empty;
   logic [NR_REQ-1:0] grant;
   logic [IDX_W-1:0]  rr_ptr_q;
   logic [IDX_W-1:0]  win_idx;
   logic              arb_vld;
   logic              kill;

   // Reset and flush both discard buffered results and silence the lane this cycle.
   assign kill = rst_i | flush_i;

   for (genvar g = 0; g < NR_REQ; g++) begin : g_req
      assign push_ent[g].trans_id = req_trans_id_i[g*TRANS_ID_BITS +: TRANS_ID_BITS];
      assign push_ent[g].data     = req_data_i[g*XLEN +: XLEN];
      assign push_ent[g].ex_valid = req_ex_valid_i[g];
      assign push_ent[g].ex_cause = req_ex_cause_i[g*XLEN +: XLEN];

      wb_fifo #(
         .WIDTH (ENTRY_W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .flush_i (flush_i),
         .push_i  (req_valid_i[g]),
         .pop_i   (grant[g]),
         .data_i  (push_ent[g]),
         .data_o  (head_ent[g]),
         .empty_o (fifo_empty[g]),
         .full_o  (fifo_full[g])
      );
   end

   // ready_o comes straight from registered occupancy, so issue logic sees no comb path.
   assign ready_o = ~fifo_full;

   // A push against a full FIFO is dropped; flag it unless the cycle is being flushed.
   assign overflow_o = ~kill & (|(req_valid_i & fifo_full));

   // Round-robin search over non-empty heads, starting at rr_ptr_q.
   always_comb begin
      logic [IDX_W-1:0] cand;
      arb_vld = 1'b0;
      win_idx = '0;
      grant   = '0;
      cand    = '0;
      for (int k = 0; k < NR_REQ; k++) begin
         cand = IDX_W'((32'(rr_ptr_q) + 32'(k)) % NR_REQ);
         if (!arb_vld && !fifo_empty[cand]) begin
            arb_vld = 1'b1;
            win_idx = cand;
         end
      end
      if (kill) begin
         arb_vld = 1'b0;
      end
      if (arb_vld) begin
         grant[win_idx] = 1'b1;
      end
   end

   // Winner's head drives the lane; idle cycles present zeros rather than stale data.
   always_comb begin
      wb_sel = '0;
      if (arb_vld) begin
         wb_sel = head_ent[win_idx];
      end
   end

   assign wb_valid_o    = arb_vld;
   assign grant_o       = grant;
   assign wb_trans_id_o = wb_sel.trans_id;
   assign wb_data_o     = wb_sel.data;
   assign wb_ex_valid_o = wb_sel.ex_valid;
   assign wb_ex_cause_o = wb_sel.ex_cause;

   // Priority pointer moves just past the last winner; it holds when nothing is granted.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         rr_ptr_q <= '0;
      end else if (arb_vld) begin
         rr_ptr_q <= (win_idx == IDX_W'(NR_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
   end

endmodule
